// File: rtl/io_uart_pkg.sv
// Shared constants, state encodings and the STATUS packing helper for io_uart.
package io_uart_pkg;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h01;
    localparam logic [7:0] ADDR_CLEAR  = 8'h02;

    localparam int STAT_RX_NEMPTY = 0;
    localparam int STAT_TX_NFULL  = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_TX_IDLE   = 3;
    localparam int STAT_FRAME_ERR = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

    function automatic logic [7:0] packStatus(input logic rxNotEmpty, input logic txNotFull,
                                              input logic overrun, input logic txIdle,
                                              input logic frameErr);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_RX_NEMPTY] = rxNotEmpty;
        s[STAT_TX_NFULL]  = txNotFull;
        s[STAT_OVERRUN]   = overrun;
        s[STAT_TX_IDLE]   = txIdle;
        s[STAT_FRAME_ERR] = frameErr;
        return s;
    endfunction

endpackage

// File: rtl/io_uart_if.sv
// CPU expansion-bus signals seen by the UART; the CPU side is the master.
interface io_uart_if;
    logic [7:0] i_bus;
    logic [7:0] o_bus;
    logic       o_busNOE;
    logic       i_ioNCE;
    logic [7:0] i_ioAddress;
    logic       i_ioNOE;
    logic       i_ioNWE;

    modport master (output i_bus, i_ioNCE, i_ioAddress, i_ioNOE, i_ioNWE,
                    input  o_bus, o_busNOE);
    modport slave  (input  i_bus, i_ioNCE, i_ioAddress, i_ioNOE, i_ioNWE,
                    output o_bus, o_busNOE);
endinterface

// File: rtl/io_uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wrPtr_r;
    logic [AW:0]      rdPtr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             doPush_s;
    logic             doPop_s;

    assign empty    = (wrPtr_r == rdPtr_r);
    assign full     = (wrPtr_r[AW] != rdPtr_r[AW]) && (wrPtr_r[AW-1:0] == rdPtr_r[AW-1:0]);
    assign doPop_s  = pop && !empty;
    assign doPush_s = push && (!full || doPop_s);
    assign popData  = mem_r[rdPtr_r[AW-1:0]];

    // storage array, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r[AW-1:0]] <= pushData;
        end
    end

    // read and write pointers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
        end else begin
            if (doPush_s) wrPtr_r <= wrPtr_r + PTR_INC;
            if (doPop_s)  rdPtr_r <= rdPtr_r + PTR_INC;
        end
    end
endmodule

// File: rtl/io_uart.sv
// 8N1 UART on the CPU expansion bus: synchronised bus decode, TX shifter, RX sampler, two FIFOs.
module io_uart
    import io_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic      i_clk100,
    input  logic      i_resetn,
    io_uart_if.slave  cpu,
    input  logic      i_serialIn,
    output logic      o_serialOut
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_INC   = {{(CW - 1){1'b0}}, 1'b1};

    logic [19:0] rawIn_s, syncA_r, syncB_r;
    logic        serialS, nceS, noeS, nweS;
    logic [7:0]  addrS, dataS;
    logic        nwePrev_r, noePrev_r, rxPrev_r;
    logic        wrCommit_s, txPush_s, clearWr_s, rxPop_s;
    logic        txEmpty_s, txFull_s, rxEmpty_s, rxFull_s, txPop_s;
    logic [7:0]  txHead_s, rxHead_s, busOut_s;
    txState_t    txState_r;
    rxState_t    rxState_r;
    logic [CW-1:0] txCnt_r, rxCnt_r;
    logic [2:0]  txBit_r, rxBit_r;
    logic [7:0]  txShift_r, rxShift_r;
    logic        txLine_r, overrun_r, frameErr_r;
    logic        rxStopPoint_s, rxPush_s, newFrameErr_s, newOverrun_s;

    assign rawIn_s = {i_serialIn, cpu.i_ioNCE, cpu.i_ioNOE, cpu.i_ioNWE, cpu.i_ioAddress, cpu.i_bus};
    assign {serialS, nceS, noeS, nweS, addrS, dataS} = syncB_r;

    // two-flop synchronisers plus edge-detect history, all idling high
    always_ff @(posedge i_clk100) begin
        if (!i_resetn) begin
            syncA_r   <= '1;
            syncB_r   <= '1;
            nwePrev_r <= 1'b1;
            noePrev_r <= 1'b1;
            rxPrev_r  <= 1'b1;
        end else begin
            syncA_r   <= rawIn_s;
            syncB_r   <= syncA_r;
            nwePrev_r <= nweS;
            noePrev_r <= noeS;
            rxPrev_r  <= serialS;
        end
    end

    assign wrCommit_s = nweS && !nwePrev_r && !nceS;
    assign txPush_s   = wrCommit_s && (addrS == ADDR_DATA);
    assign clearWr_s  = wrCommit_s && (addrS == ADDR_CLEAR);
    assign rxPop_s    = noeS && !noePrev_r && !nceS && (addrS == ADDR_DATA) && !rxEmpty_s;
    assign txPop_s    = !txEmpty_s && ((txState_r == TX_IDLE) ||
                                       ((txState_r == TX_STOP) && (txCnt_r == BIT_LAST)));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk(i_clk100), .resetn(i_resetn), .push(txPush_s), .pushData(dataS),
        .pop(txPop_s), .popData(txHead_s), .empty(txEmpty_s), .full(txFull_s));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk(i_clk100), .resetn(i_resetn), .push(rxPush_s), .pushData(rxShift_r),
        .pop(rxPop_s), .popData(rxHead_s), .empty(rxEmpty_s), .full(rxFull_s));

    // TX shifter; the line register follows the state one cycle later
    always_ff @(posedge i_clk100) begin
        if (!i_resetn) begin
            txState_r <= TX_IDLE;
            txCnt_r   <= '0;
            txBit_r   <= 3'd0;
            txShift_r <= 8'h00;
            txLine_r  <= 1'b1;
        end else begin
            txLine_r <= (txState_r == TX_START) ? 1'b0 :
                        (txState_r == TX_DATA)  ? txShift_r[0] : 1'b1;
            case (txState_r)
                TX_IDLE: begin
                    if (txPop_s) begin
                        txShift_r <= txHead_s;
                        txCnt_r   <= '0;
                        txState_r <= TX_START;
                    end
                end
                TX_START: begin
                    if (txCnt_r == BIT_LAST) begin
                        txCnt_r   <= '0;
                        txBit_r   <= 3'd0;
                        txState_r <= TX_DATA;
                    end else begin
                        txCnt_r <= txCnt_r + CNT_INC;
                    end
                end
                TX_DATA: begin
                    if (txCnt_r == BIT_LAST) begin
                        txCnt_r   <= '0;
                        txShift_r <= {1'b0, txShift_r[7:1]};
                        if (txBit_r == 3'd7) txState_r <= TX_STOP;
                        else                 txBit_r   <= txBit_r + 3'd1;
                    end else begin
                        txCnt_r <= txCnt_r + CNT_INC;
                    end
                end
                TX_STOP: begin
                    if (txCnt_r == BIT_LAST) begin
                        txCnt_r <= '0;
                        if (txPop_s) begin
                            txShift_r <= txHead_s;
                            txState_r <= TX_START;
                        end else begin
                            txState_r <= TX_IDLE;
                        end
                    end else begin
                        txCnt_r <= txCnt_r + CNT_INC;
                    end
                end
                default: txState_r <= TX_IDLE;
            endcase
        end
    end

    assign rxStopPoint_s = (rxState_r == RX_STOP) && (rxCnt_r == BIT_LAST);
    assign rxPush_s      = rxStopPoint_s && serialS;
    assign newFrameErr_s = rxStopPoint_s && !serialS;
    assign newOverrun_s  = rxPush_s && rxFull_s && !rxPop_s;

    // RX sampler: mid-bit sampling anchored on the start-bit midpoint
    always_ff @(posedge i_clk100) begin
        if (!i_resetn) begin
            rxState_r <= RX_IDLE;
            rxCnt_r   <= '0;
            rxBit_r   <= 3'd0;
            rxShift_r <= 8'h00;
        end else begin
            case (rxState_r)
                RX_IDLE: begin
                    if (rxPrev_r && !serialS) begin
                        rxCnt_r   <= '0;
                        rxState_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (rxCnt_r == HALF_LAST) begin
                        rxCnt_r   <= '0;
                        rxBit_r   <= 3'd0;
                        rxState_r <= serialS ? RX_IDLE : RX_DATA;
                    end else begin
                        rxCnt_r <= rxCnt_r + CNT_INC;
                    end
                end
                RX_DATA: begin
                    if (rxCnt_r == BIT_LAST) begin
                        rxCnt_r   <= '0;
                        rxShift_r <= {serialS, rxShift_r[7:1]};
                        if (rxBit_r == 3'd7) rxState_r <= RX_STOP;
                        else                 rxBit_r   <= rxBit_r + 3'd1;
                    end else begin
                        rxCnt_r <= rxCnt_r + CNT_INC;
                    end
                end
                RX_STOP: begin
                    if (rxCnt_r == BIT_LAST) rxState_r <= RX_IDLE;
                    else                     rxCnt_r   <= rxCnt_r + CNT_INC;
                end
                default: rxState_r <= RX_IDLE;
            endcase
        end
    end

    // sticky error flags; a new error in the same cycle as CLEAR keeps the flag set
    always_ff @(posedge i_clk100) begin
        if (!i_resetn) begin
            overrun_r  <= 1'b0;
            frameErr_r <= 1'b0;
        end else begin
            if (newOverrun_s)    overrun_r  <= 1'b1;
            else if (clearWr_s)  overrun_r  <= 1'b0;
            if (newFrameErr_s)   frameErr_r <= 1'b1;
            else if (clearWr_s)  frameErr_r <= 1'b0;
        end
    end

    // read mux keyed on the raw address so data is ready within the CPU's own cycle
    always_comb begin
        busOut_s = 8'hFF;
        case (cpu.i_ioAddress)
            ADDR_DATA:   busOut_s = rxEmpty_s ? 8'h00 : rxHead_s;
            ADDR_STATUS: busOut_s = packStatus(!rxEmpty_s, !txFull_s, overrun_r,
                                               txEmpty_s && (txState_r == TX_IDLE), frameErr_r);
            ADDR_CLEAR:  busOut_s = 8'h00;
            default:     busOut_s = 8'hFF;
        endcase
    end

    assign cpu.o_bus    = busOut_s;
    assign cpu.o_busNOE = cpu.i_ioNCE | cpu.i_ioNOE;
    assign o_serialOut  = txLine_r;
endmodule
